// File: rtl/sprite_ram_loader.sv
// sprite_ram_loader
//   Run-time loadable sprite store. A host streams 4-bit colour-index images into one of
//   NUM_SPRITES slots, two pixels per byte. The read side behaves like a sprite ROM, so the
//   drawing logic can swap it in for any ROM frame.
// Ports
//   Clk, Reset                - clock (rising edge), asynchronous active-high reset
//   start, sprite_sel         - begin loading slot sprite_sel (1-cycle pulse)
//   in_data, in_valid         - pixel pair stream, [3:0] even pixel, [7:4] odd pixel
//   in_ready                  - a byte is accepted when in_valid && in_ready
//   busy, done, error         - load in progress / load finished pulse / bad slot pulse
//   read_sprite, read_address - slot and pixel offset to read
//   color_idx                 - colour index, one cycle after the read address
module sprite_ram_loader #(
  parameter int unsigned PIXELS      = 480,
  parameter int unsigned NUM_SPRITES = 6,
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned SEL_W       = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [SEL_W-1:0]  sprite_sel,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [SEL_W-1:0]  read_sprite,
  input  logic [ADDR_W-1:0] read_address,
  output logic [3:0]        color_idx
);

  localparam int unsigned Half  = PIXELS / 2;
  localparam int unsigned Depth = NUM_SPRITES * Half;
  localparam int unsigned MemAw = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Half);

  localparam logic [CntW-1:0]  LastCnt = CntW'(Half - 1);
  localparam logic [MemAw-1:0] HalfAw  = MemAw'(Half);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MemAw-1:0] base_q, base_d;
  logic             error_q, error_d;
  logic             wr_en;
  logic [MemAw-1:0] wr_addr;

  logic [7:0]       mem [Depth];
  logic             rd_in_range;
  logic [MemAw-1:0] rd_addr;
  logic [7:0]       rd_data_q;
  logic             rd_ok_q;
  logic             rd_odd_q;

  // Handshake outputs decode the state register only, never in_valid.
  assign in_ready = (state_q == StLoad);
  assign busy     = (state_q == StLoad);
  assign done     = (state_q == StDone);
  assign error    = error_q;

  assign wr_addr = base_q + MemAw'(cnt_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    error_d = 1'b0;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (32'(sprite_sel) < NUM_SPRITES) begin
            state_d = StLoad;
            cnt_d   = '0;
            base_d  = MemAw'(sprite_sel) * HalfAw;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      StLoad: begin
        // start is deliberately not looked at here; the latched slot holds for the whole load.
        if (in_valid) begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      base_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      error_q <= error_d;
    end
  end

  // Out-of-range reads are steered to byte 0 and masked to the transparent index later.
  assign rd_in_range = (32'(read_address) < PIXELS) && (32'(read_sprite) < NUM_SPRITES);
  assign rd_addr     = rd_in_range ?
                       MemAw'(read_sprite) * HalfAw + MemAw'(read_address >> 1) : '0;

  // RAM has no reset so it maps onto block RAM; the read sees the pre-write byte.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= in_data;
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ok_q  <= 1'b0;
      rd_odd_q <= 1'b0;
    end else begin
      rd_ok_q  <= rd_in_range;
      rd_odd_q <= read_address[0];
    end
  end

  always_comb begin
    color_idx = 4'h0;
    if (rd_ok_q) color_idx = rd_odd_q ? rd_data_q[7:4] : rd_data_q[3:0];
  end

endmodule
